// File: rtl/gpr_pkg.sv
// Shared definitions for the GPR execution unit: opcodes, instruction-field
// slicing, FSM states and flag bit positions.
package gpr_pkg;

    localparam logic [4:0] OP_MOVSGPR = 5'd0;
    localparam logic [4:0] OP_MOV     = 5'd1;
    localparam logic [4:0] OP_ADD     = 5'd2;
    localparam logic [4:0] OP_SUB     = 5'd3;
    localparam logic [4:0] OP_MUL     = 5'd4;
    localparam logic [4:0] OP_ROR     = 5'd5;
    localparam logic [4:0] OP_RAND    = 5'd6;
    localparam logic [4:0] OP_RXOR    = 5'd7;
    localparam logic [4:0] OP_RXNOR   = 5'd8;
    localparam logic [4:0] OP_RNAND   = 5'd9;
    localparam logic [4:0] OP_RNOR    = 5'd10;
    localparam logic [4:0] OP_RNOT    = 5'd11;

    // Positions inside flags = {Z,S,C,V}
    localparam int FLAG_Z = 3;
    localparam int FLAG_S = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2
    } state_e;

    function automatic logic [4:0] ir_op(input logic [31:0] ir);
        return ir[31:27];
    endfunction

    function automatic logic [4:0] ir_rdst(input logic [31:0] ir);
        return ir[26:22];
    endfunction

    function automatic logic [4:0] ir_rsrc1(input logic [31:0] ir);
        return ir[21:17];
    endfunction

    function automatic logic ir_imm(input logic [31:0] ir);
        return ir[16];
    endfunction

    function automatic logic [4:0] ir_rsrc2(input logic [31:0] ir);
        return ir[15:11];
    endfunction

    function automatic logic [15:0] ir_isrc(input logic [31:0] ir);
        return ir[15:0];
    endfunction

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle,
// DW cycles per product, done pulses for one cycle with p valid.
module seq_mul #(
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic            busy,
    output logic            done,
    output logic [2*DW-1:0] p
);

    localparam int CW = $clog2(DW + 1);

    logic [DW-1:0]   mcand_q, mcand_d;
    logic [2*DW-1:0] prod_q, prod_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [DW:0]     sum;

    // prod holds {partial sum, remaining multiplier bits}; it shifts right each step
    always_comb begin
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum     = {1'b0, prod_q[2*DW-1:DW]} + (prod_q[0] ? {1'b0, mcand_q} : {(DW+1){1'b0}});
        if (start && !busy_q) begin
            mcand_d = a;
            prod_d  = {{DW{1'b0}}, b};
            cnt_d   = CW'(DW);
            busy_d  = 1'b1;
        end else if (busy_q) begin
            prod_d = {sum, prod_q[DW-1:1]};
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = prod_q;

endmodule

// File: rtl/gpr_exec_unit.sv
// Clocked GPR execution unit: accepts one instruction per handshake, runs it
// against an NREG x DW register file and updates {Z,S,C,V}; multiply is iterative.
module gpr_exec_unit
    import gpr_pkg::*;
#(
    parameter int DW   = 16,
    parameter int NREG = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [31:0]   instr,
    output logic          done,
    output logic          illegal,
    output logic [3:0]    flags,
    output logic [DW-1:0] sgpr,
    input  logic [4:0]    dbg_addr,
    output logic [DW-1:0] dbg_data
);

    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

    logic [DW-1:0] gpr_q [NREG];

    state_e        state_q, state_d;
    logic [4:0]    op_q, op_d;
    logic [4:0]    rd_q, rd_d;
    logic [DW-1:0] opa_q, opa_d;
    logic [DW-1:0] opb_q, opb_d;
    logic [3:0]    flags_q, flags_d;
    logic [DW-1:0] sgpr_q, sgpr_d;
    logic          done_q, done_d;
    logic          illegal_q, illegal_d;

    logic            accept;
    logic [DW-1:0]   opa, opb;
    logic            wr_en, flag_upd, c_new, v_new;
    logic [DW-1:0]   res;
    logic [DW:0]     sum, diff;
    logic            mul_start, mul_busy, mul_done;
    logic [2*DW-1:0] mul_p;

    function automatic logic in_range(input logic [4:0] idx);
        return 32'(idx) < NREG;
    endfunction

    function automatic logic [DW-1:0] rd_gpr(input logic [4:0] idx);
        return in_range(idx) ? gpr_q[idx[AW-1:0]] : '0;
    endfunction

    // Handshake: an instruction transfers on a rising edge where instr_valid and
    // instr_ready are both high; ready is high only while IDLE and is never
    // dependent on valid, so a held valid simply waits out EXEC/MUL.
    assign instr_ready = (state_q == IDLE) && !mul_busy;
    assign accept      = instr_valid && instr_ready;

    assign opa = rd_gpr(ir_rsrc1(instr));
    assign opb = ir_imm(instr) ? DW'(ir_isrc(instr)) : rd_gpr(ir_rsrc2(instr));

    assign sum  = {1'b0, opa_q} + {1'b0, opb_q};
    assign diff = {1'b0, opa_q} - {1'b0, opb_q};

    assign mul_start = accept && (ir_op(instr) == OP_MUL);

    seq_mul #(.DW(DW)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (opa),
        .b     (opb),
        .busy  (mul_busy),
        .done  (mul_done),
        .p     (mul_p)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        flags_d   = flags_q;
        sgpr_d    = sgpr_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        wr_en     = 1'b0;
        flag_upd  = 1'b0;
        c_new     = 1'b0;
        v_new     = 1'b0;
        res       = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = ir_op(instr);
                    rd_d    = ir_rdst(instr);
                    opa_d   = opa;
                    opb_d   = opb;
                    state_d = (ir_op(instr) == OP_MUL) ? MUL : EXEC;
                end
            end
            EXEC: begin
                state_d  = IDLE;
                done_d   = 1'b1;
                wr_en    = 1'b1;
                flag_upd = 1'b1;
                case (op_q)
                    OP_MOVSGPR: begin res = sgpr_q; flag_upd = 1'b0; end
                    OP_MOV:     begin res = opb_q;  flag_upd = 1'b0; end
                    OP_ADD: begin
                        res   = sum[DW-1:0];
                        c_new = sum[DW];
                        v_new = (opa_q[DW-1] == opb_q[DW-1]) && (res[DW-1] != opa_q[DW-1]);
                    end
                    OP_SUB: begin
                        res   = diff[DW-1:0];
                        c_new = diff[DW];
                        v_new = (opa_q[DW-1] != opb_q[DW-1]) && (res[DW-1] != opa_q[DW-1]);
                    end
                    OP_ROR:   res = opa_q | opb_q;
                    OP_RAND:  res = opa_q & opb_q;
                    OP_RXOR:  res = opa_q ^ opb_q;
                    OP_RXNOR: res = ~(opa_q ^ opb_q);
                    OP_RNAND: res = ~(opa_q & opb_q);
                    OP_RNOR:  res = ~(opa_q | opb_q);
                    OP_RNOT:  res = ~opa_q;
                    default: begin
                        wr_en     = 1'b0;
                        flag_upd  = 1'b0;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MUL: begin
                if (mul_done) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    wr_en    = 1'b1;
                    flag_upd = 1'b1;
                    res      = mul_p[DW-1:0];
                    sgpr_d   = mul_p[2*DW-1:DW];
                    c_new    = |mul_p[2*DW-1:DW];
                end
            end
            default: state_d = IDLE;
        endcase
        if (flag_upd) begin
            flags_d[FLAG_Z] = (res == '0);
            flags_d[FLAG_S] = res[DW-1];
            flags_d[FLAG_C] = c_new;
            flags_d[FLAG_V] = v_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            rd_q      <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            flags_q   <= '0;
            sgpr_q    <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            op_q      <= op_d;
            rd_q      <= rd_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            flags_q   <= flags_d;
            sgpr_q    <= sgpr_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    // Writes to indices beyond the file are dropped; retirement still signals done
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
        end else if (wr_en && in_range(rd_q)) begin
            gpr_q[rd_q[AW-1:0]] <= res;
        end
    end

    assign done     = done_q;
    assign illegal  = illegal_q;
    assign flags    = flags_q;
    assign sgpr     = sgpr_q;
    assign dbg_data = rd_gpr(dbg_addr);

endmodule

// File: tb/tb_gpr_exec_unit.sv
// Directed bench for gpr_exec_unit: an instruction-level model predicts register
// file, flags, sgpr and handshake timing; a negedge process compares every cycle.
module tb_gpr_exec_unit;

    localparam int DW = 16;

    localparam logic [4:0] MOVSGPR = 5'd0, MOV = 5'd1, ADD = 5'd2, SUB = 5'd3, MULOP = 5'd4;
    localparam logic [4:0] LOR = 5'd5, LAND = 5'd6, LXOR = 5'd7, LXNOR = 5'd8;
    localparam logic [4:0] LNAND = 5'd9, LNOR = 5'd10, LNOT = 5'd11, BADOP = 5'd31;

    logic          clk = 1'b0;
    logic          rst;
    logic          instr_valid;
    logic [31:0]   instr;
    logic          instr_ready, done, illegal;
    logic [3:0]    flags;
    logic [DW-1:0] sgpr, dbg_data;
    logic [4:0]    dbg_addr = 5'd0;

    logic          instr_ready8, done8, illegal8;
    logic [3:0]    flags8;
    logic [DW-1:0] sgpr8, dbg_data8;
    logic [4:0]    dbg_addr8 = 5'd0;

    gpr_exec_unit #(.DW(DW), .NREG(32)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .done(done), .illegal(illegal), .flags(flags), .sgpr(sgpr),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    gpr_exec_unit #(.DW(DW), .NREG(8)) dut8 (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready8),
        .instr(instr), .done(done8), .illegal(illegal8), .flags(flags8), .sgpr(sgpr8),
        .dbg_addr(dbg_addr8), .dbg_data(dbg_data8)
    );

    always #5 clk = ~clk;

    // ---------------- model state ----------------
    logic [DW-1:0] m_rf [32];
    logic [DW-1:0] m_sgpr;
    logic [3:0]    m_flags;
    logic [DW-1:0] p_val, p_sgpr;
    logic [3:0]    p_flags;
    logic          p_wr, p_ill, p_mul;
    logic [4:0]    p_rd;
    logic          exp_ready, exp_done, exp_illegal;
    bit            chk_en = 1'b0;
    bit            reported = 1'b0;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [15:0] imm);
        return {op, rd, rs1, 1'b1, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {op, rd, rs1, 1'b0, rs2, 11'd0};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_sgpr  = '0;
        m_flags = '0;
    endtask

    function automatic int to_signed(input int unsigned v);
        return (v >= 32768) ? int'(v) - 65536 : int'(v);
    endfunction

    // Instruction semantics in plain integer arithmetic
    task automatic model_exec(input logic [31:0] ins);
        int unsigned a, b, r, full;
        int s;
        bit upd, c, v;
        a = 32'(m_rf[ins[21:17]]);
        b = ins[16] ? 32'(ins[15:0]) : 32'(m_rf[ins[15:11]]);
        p_rd = ins[26:22];
        p_wr = 1'b1; p_ill = 1'b0; p_mul = 1'b0;
        p_flags = m_flags; p_sgpr = m_sgpr;
        upd = 1'b1; c = 1'b0; v = 1'b0; r = 0;
        case (ins[31:27])
            MOVSGPR: begin r = 32'(m_sgpr); upd = 1'b0; end
            MOV:     begin r = b; upd = 1'b0; end
            ADD: begin
                full = a + b; r = full % 65536; c = (full >= 65536);
                s = to_signed(a) + to_signed(b); v = (s > 32767) || (s < -32768);
            end
            SUB: begin
                r = (a + 65536 - b) % 65536; c = (a < b);
                s = to_signed(a) - to_signed(b); v = (s > 32767) || (s < -32768);
            end
            MULOP: begin
                full = a * b; r = full % 65536; p_sgpr = 16'(full / 65536);
                c = (full / 65536) != 0; p_mul = 1'b1;
            end
            LOR:   r = a | b;
            LAND:  r = a & b;
            LXOR:  r = a ^ b;
            LXNOR: r = ~(a ^ b) & 32'hFFFF;
            LNAND: r = ~(a & b) & 32'hFFFF;
            LNOR:  r = ~(a | b) & 32'hFFFF;
            LNOT:  r = ~a & 32'hFFFF;
            default: begin p_wr = 1'b0; p_ill = 1'b1; upd = 1'b0; end
        endcase
        p_val = 16'(r);
        if (upd) p_flags = {r == 0, r >= 32768, c, v};
    endtask

    task automatic model_commit();
        if (p_wr) m_rf[p_rd] = p_val;
        m_sgpr  = p_sgpr;
        m_flags = p_flags;
    endtask

    // Present an instruction, keep valid high until it retires
    task automatic issue(input logic [31:0] ins);
        @(negedge clk);
        rst = 1'b0;
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        model_exec(ins);
        exp_ready = 1'b0; exp_done = 1'b0; exp_illegal = 1'b0;
        repeat (p_mul ? DW + 1 : 1) @(posedge clk);
        #1;
        model_commit();
        exp_done = 1'b1; exp_illegal = p_ill; exp_ready = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rst = 1'b0;
            instr_valid = 1'b0;
            @(posedge clk); #1;
            exp_done = 1'b0; exp_illegal = 1'b0;
        end
    endtask

    task automatic report();
        if (!reported) begin
            reported = 1'b1;
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    initial begin
        wait (chk_en);
        forever begin
            @(negedge clk);
            chk("instr_ready", 32'(instr_ready), 32'(exp_ready));
            chk("done", 32'(done), 32'(exp_done));
            chk("illegal", 32'(illegal), 32'(exp_illegal));
            chk("flags", 32'(flags), 32'(m_flags));
            chk("sgpr", 32'(sgpr), 32'(m_sgpr));
            chk("dbg_data", 32'(dbg_data), 32'(m_rf[dbg_addr]));
            chk("n8_ready", 32'(instr_ready8), 32'(exp_ready));
            chk("n8_done", 32'(done8), 32'(exp_done));
            chk("n8_illegal", 32'(illegal8), 32'(exp_illegal));
            dbg_addr = dbg_addr + 5'd1;
        end
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        report();
        $finish;
    end

    // ---------------- directed stimulus ----------------
    initial begin
        // 1: reset with a valid instruction presented; reset must win
        rst = 1'b1;
        instr_valid = 1'b1;
        instr = enc_i(MOV, 5'd1, 5'd0, 16'h0005);
        model_reset();
        exp_ready = 1'b1; exp_done = 1'b0; exp_illegal = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        idle(34);

        // 2: add with carry out
        issue(enc_i(MOV, 5'd1, 5'd0, 16'h0005));
        issue(enc_i(ADD, 5'd2, 5'd1, 16'hFFFF));
        chk("t2_flags", 32'(flags), 32'h2);
        chk("t2_model_r2", 32'(m_rf[2]), 32'h0004);

        // 3: multiply, then move the high half out
        issue(enc_i(MOV, 5'd1, 5'd0, 16'h1234));
        issue(enc_i(MULOP, 5'd3, 5'd1, 16'h0100));
        chk("t3_sgpr", 32'(sgpr), 32'h0012);
        chk("t3_flags", 32'(flags), 32'h2);
        chk("t3_model_r3", 32'(m_rf[3]), 32'h3400);
        issue(enc_r(MOVSGPR, 5'd4, 5'd0, 5'd0));
        chk("t3_model_r4", 32'(m_rf[4]), 32'h0012);

        // 4: zero result and signed overflow
        issue(enc_r(SUB, 5'd5, 5'd1, 5'd1));
        chk("t4_sub_flags", 32'(flags), 32'h8);
        issue(enc_i(MOV, 5'd6, 5'd0, 16'h7FFF));
        issue(enc_i(ADD, 5'd7, 5'd6, 16'h0001));
        chk("t4_add_flags", 32'(flags), 32'h5);
        chk("t4_model_r7", 32'(m_rf[7]), 32'h8000);

        // Logic ops, aliasing and a signed-looking multiply
        issue(enc_r(LOR,   5'd8,  5'd1, 5'd6));
        issue(enc_r(LAND,  5'd9,  5'd1, 5'd7));
        issue(enc_i(LXOR,  5'd10, 5'd1, 16'h00FF));
        issue(enc_r(LXNOR, 5'd11, 5'd1, 5'd6));
        issue(enc_r(LNAND, 5'd12, 5'd6, 5'd7));
        issue(enc_r(LNOR,  5'd13, 5'd1, 5'd7));
        issue(enc_i(LNOT,  5'd14, 5'd1, 16'hFFFF));
        chk("lnot_model", 32'(m_rf[14]), 32'hEDCB);
        issue(enc_r(ADD,   5'd1,  5'd1, 5'd1));
        chk("alias_model", 32'(m_rf[1]), 32'h2468);
        issue(enc_r(MULOP, 5'd15, 5'd6, 5'd7));
        chk("mul2_sgpr", 32'(sgpr), 32'h3FFF);
        issue(enc_r(SUB,   5'd16, 5'd6, 5'd7));
        chk("sub_ovf_flags", 32'(flags), 32'h7);
        idle(3);

        // 5: undefined opcode, then out-of-range index on the NREG=8 instance
        issue({BADOP, 5'd2, 5'd1, 1'b1, 16'h0001});
        chk("t5_illegal", 32'(illegal), 32'h1);
        chk("t5_flags_kept", 32'(flags), 32'h7);
        issue(enc_i(MOV, 5'd9, 5'd0, 16'h0007));
        dbg_addr8 = 5'd9; #1;
        chk("t5_n8_r9", 32'(dbg_data8), 32'h0);
        issue(enc_i(ADD, 5'd2, 5'd9, 16'h0001));
        dbg_addr8 = 5'd2; #1;
        chk("t5_n8_r2", 32'(dbg_data8), 32'h1);
        chk("t5_model_r2", 32'(m_rf[2]), 32'h0008);

        // 6: reset in MUL cycle 5 with valid held high
        @(negedge clk);
        instr = enc_i(MULOP, 5'd3, 5'd1, 16'h0100);
        instr_valid = 1'b1;
        @(posedge clk); #1;
        exp_ready = 1'b0; exp_done = 1'b0; exp_illegal = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        model_reset();
        exp_ready = 1'b1;
        chk("t6_sgpr_after_rst", 32'(sgpr), 32'h0);
        issue(enc_i(MULOP, 5'd3, 5'd1, 16'h0100));
        chk("t6_flags", 32'(flags), 32'h8);
        idle(34);

        report();
        $finish;
    end

endmodule
